// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite fetch / fade stage.
// The optional fade sequencer is enabled by defining SPRITE_FADE_EN.
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FADE_IN,
        HOLD,
        FADE_OUT
    } fade_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] a;
    } rgba_t;

    localparam logic [7:0] LEVEL_MAX = 8'd255;
    localparam int         PIPE_LAT  = 3;

    // Rounds up so that level 255 passes the texel alpha through unchanged.
    function automatic logic [7:0] scale_alpha(input logic [7:0] a, input logic [7:0] level);
        logic [15:0] p;
        p = 16'(a) * 16'(level) + 16'd255;
        return p[15:8];
    endfunction

endpackage

// File: rtl/sprite_fade_fsm.sv
// Frame-stepped fade-in / hold / fade-out level generator.
// Only instantiated when SPRITE_FADE_EN is defined.
module sprite_fade_fsm
    import sprite_pkg::*;
#(
    parameter int FADE_STEP   = 8,
    parameter int HOLD_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_frame_start,
    input  logic       i_fade_start,
    output logic [7:0] o_level,
    output logic       o_fade_busy
);

    localparam int                CNT_W     = $clog2(HOLD_FRAMES + 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_FRAMES);
    localparam logic [8:0]        STEP9     = 9'(FADE_STEP);

    fade_state_t      r_state, w_state_nxt;
    logic [7:0]       r_level, w_level_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic             r_busy;
    logic [8:0]       w_sum, w_diff;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_sum     = {1'b0, r_level} + STEP9;
    assign w_diff    = {1'b0, r_level} - STEP9;
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (i_fade_start) begin
                    w_state_nxt = FADE_IN;
                    w_level_nxt = 8'd0;
                end
            end
            FADE_IN: begin
                if (i_frame_start) begin
                    if (w_sum >= {1'b0, LEVEL_MAX}) begin
                        w_level_nxt = LEVEL_MAX;
                        w_state_nxt = HOLD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_level_nxt = w_sum[7:0];
                    end
                end
            end
            HOLD: begin
                if (i_frame_start) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == HOLD_LAST) w_state_nxt = FADE_OUT;
                end
            end
            FADE_OUT: begin
                // A borrow into bit 8 means the step overshot zero.
                if (i_frame_start) begin
                    if (w_diff[8] || (w_diff[7:0] == 8'd0)) begin
                        w_level_nxt = 8'd0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_level_nxt = w_diff[7:0];
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_level <= 8'd0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    assign o_level     = r_level;
    assign o_fade_busy = r_busy;

endmodule

// File: rtl/sprite_fetch_fade.sv
// Sprite hit test, texel fetch and alpha fade ahead of the pixel blender (3-stage pipe).
// Define SPRITE_FADE_EN to enable the fade sequencer; otherwise alpha equals texel alpha.
module sprite_fetch_fade
    import sprite_pkg::*;
#(
    parameter int SPRITE_W    = 32,
    parameter int SPRITE_H    = 32,
    parameter int COORD_W     = 10,
    parameter int ADDR_W      = 10,
    parameter int FADE_STEP   = 8,
    parameter int HOLD_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] sprite_x,
    input  logic [COORD_W-1:0] sprite_y,
    input  logic               fade_start,
    output logic               fade_busy,
    input  logic               pixel_valid,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic [7:0]         sdram_R,
    input  logic [7:0]         sdram_G,
    input  logic [7:0]         sdram_B,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [31:0]        rom_data,
    output logic               out_valid,
    output logic [7:0]         sprite_R,
    output logic [7:0]         sprite_G,
    output logic [7:0]         sprite_B,
    output logic [7:0]         alpha,
    output logic [7:0]         bg_R,
    output logic [7:0]         bg_G,
    output logic [7:0]         bg_B
);

    localparam int                 SW_LOG = $clog2(SPRITE_W);
    localparam logic [COORD_W-1:0] SW_C   = COORD_W'(SPRITE_W);
    localparam logic [COORD_W-1:0] SH_C   = COORD_W'(SPRITE_H);

    logic [7:0] w_level;

`ifdef SPRITE_FADE_EN
    sprite_fade_fsm #(
        .FADE_STEP  (FADE_STEP),
        .HOLD_FRAMES(HOLD_FRAMES)
    ) u_fade_fsm (
        .clk          (clk),
        .reset        (reset),
        .i_frame_start(frame_start),
        .i_fade_start (fade_start),
        .o_level      (w_level),
        .o_fade_busy  (fade_busy)
    );
`else
    logic w_unused_fade;
    assign w_unused_fade = ^{fade_start, 32'(FADE_STEP), 32'(HOLD_FRAMES)};
    assign w_level       = LEVEL_MAX;
    assign fade_busy     = 1'b0;
`endif

    logic [COORD_W-1:0] r_sx, r_sy;
    logic [COORD_W-1:0] w_dx, w_dy;
    logic               w_hit;
    logic [ADDR_W-1:0]  w_addr;
    rgba_t              w_texel;

    logic               r_v1, r_hit1, r_v2, r_hit2;
    logic [23:0]        r_bg1, r_bg2;
    logic [ADDR_W-1:0]  r_rom_addr;

    logic               r_out_valid;
    logic [7:0]         r_spr_r, r_spr_g, r_spr_b, r_alpha;
    logic [23:0]        r_bg_out;

    // Unsigned wrap of the differences is harmless: the >= tests reject it.
    assign w_dx    = pixel_x - r_sx;
    assign w_dy    = pixel_y - r_sy;
    assign w_hit   = (pixel_x >= r_sx) && (w_dx < SW_C) && (pixel_y >= r_sy) && (w_dy < SH_C);
    assign w_addr  = (ADDR_W'(w_dy) << SW_LOG) + ADDR_W'(w_dx);
    assign w_texel = rgba_t'(rom_data);

    // E1: position latch, hit test, ROM address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sx       <= '0;
            r_sy       <= '0;
            r_v1       <= 1'b0;
            r_hit1     <= 1'b0;
            r_bg1      <= '0;
            r_rom_addr <= '0;
        end else begin
            if (frame_start) begin
                r_sx <= sprite_x;
                r_sy <= sprite_y;
            end
            r_v1 <= pixel_valid;
            if (pixel_valid) begin
                r_hit1     <= w_hit;
                r_bg1      <= {sdram_R, sdram_G, sdram_B};
                r_rom_addr <= w_hit ? w_addr : '0;
            end
        end
    end

    // E2: ROM access in flight; sideband delayed alongside.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v2   <= 1'b0;
            r_hit2 <= 1'b0;
            r_bg2  <= '0;
        end else begin
            r_v2   <= r_v1;
            r_hit2 <= r_hit1;
            r_bg2  <= r_bg1;
        end
    end

    // E3: output register; data holds through bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_spr_r     <= 8'd0;
            r_spr_g     <= 8'd0;
            r_spr_b     <= 8'd0;
            r_alpha     <= 8'd0;
            r_bg_out    <= '0;
        end else begin
            r_out_valid <= r_v2;
            if (r_v2) begin
                r_spr_r  <= r_hit2 ? w_texel.r : 8'd0;
                r_spr_g  <= r_hit2 ? w_texel.g : 8'd0;
                r_spr_b  <= r_hit2 ? w_texel.b : 8'd0;
                r_alpha  <= r_hit2 ? scale_alpha(w_texel.a, w_level) : 8'd0;
                r_bg_out <= r_bg2;
            end
        end
    end

    assign rom_addr  = r_rom_addr;
    assign out_valid = r_out_valid;
    assign sprite_R  = r_spr_r;
    assign sprite_G  = r_spr_g;
    assign sprite_B  = r_spr_b;
    assign alpha     = r_alpha;
    assign bg_R      = r_bg_out[23:16];
    assign bg_G      = r_bg_out[15:8];
    assign bg_B      = r_bg_out[7:0];

endmodule

// File: tb/tb_sprite_fetch_fade.sv
// Scoreboard bench for sprite_fetch_fade; fade scenarios run when SPRITE_FADE_EN is defined.
`timescale 1ns/1ps
module tb_sprite_fetch_fade;
    import sprite_pkg::*;

    logic       clk = 1'b0;
    logic       reset, frame_start, fade_start, pixel_valid;
    logic [9:0] sprite_x, sprite_y, pixel_x, pixel_y;
    logic [7:0] sdram_R, sdram_G, sdram_B;
    logic [9:0] rom_addr;
    logic [31:0] rom_data;
    logic       fade_busy, out_valid;
    logic [7:0] sprite_R, sprite_G, sprite_B, alpha, bg_R, bg_G, bg_B;

    logic [7:0] rom_a = 8'hFF;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         hold_chk = 1'b0;
`ifdef SPRITE_FADE_EN
    logic [7:0] model_level = 8'd0;
`else
    logic [7:0] model_level = 8'd255;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] sr, sg, sb, a, br, bgc, bb;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;
    exp_t mon_last;

    sprite_fetch_fade #(
        .SPRITE_W(32), .SPRITE_H(32), .COORD_W(10), .ADDR_W(10),
        .FADE_STEP(8), .HOLD_FRAMES(60)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .sprite_x(sprite_x), .sprite_y(sprite_y),
        .fade_start(fade_start), .fade_busy(fade_busy),
        .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .sdram_R(sdram_R), .sdram_G(sdram_G), .sdram_B(sdram_B),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid),
        .sprite_R(sprite_R), .sprite_G(sprite_G), .sprite_B(sprite_B),
        .alpha(alpha), .bg_R(bg_R), .bg_G(bg_G), .bg_B(bg_B)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM: texel = {addr[7:0], 0x11, 0x22, A}.
    always @(posedge clk) rom_data <= {rom_addr[7:0], 8'h11, 8'h22, rom_a};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] alpha_of(input logic [7:0] a, input logic [7:0] lvl);
        int p;
        p = (int'(a) * int'(lvl) + 255) >> 8;
        return 8'(p);
    endfunction

    // Drives one valid pixel on the next cycle; expected response is queued.
    task automatic send_pixel(input int x, input int y, input bit hit,
                              input logic [7:0] sr, input logic [7:0] a);
        exp_t e;
        @(negedge clk);
        pixel_valid = 1'b1;
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        sdram_R = 8'(x);
        sdram_G = 8'(y);
        sdram_B = 8'h5A;
        e.cyc = cyc + PIPE_LAT;
        e.sr  = hit ? sr : 8'd0;
        e.sg  = hit ? 8'h11 : 8'd0;
        e.sb  = hit ? 8'h22 : 8'd0;
        e.a   = hit ? a : 8'd0;
        e.br  = 8'(x);
        e.bgc = 8'(y);
        e.bb  = 8'h5A;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pixel_valid = 1'b0;
        end
    endtask

    task automatic latch_pos();
        @(negedge clk);
        pixel_valid = 1'b0;
        sprite_x = 10'd100;
        sprite_y = 10'd50;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

`ifdef SPRITE_FADE_EN
    task automatic frame(input bit with_fade, input logic [7:0] exp_level, input bit exp_busy);
        @(negedge clk);
        pixel_valid = 1'b0;
        frame_start = 1'b1;
        fade_start  = with_fade;
        @(negedge clk);
        frame_start = 1'b0;
        fade_start  = 1'b0;
        check("fade_busy", fade_busy, exp_busy);
        model_level = exp_level;
        send_pixel(103, 52, 1'b1, 8'd67, alpha_of(8'hFF, exp_level));
        idle(3);
    endtask
`endif

    // Monitor: pops and compares whenever the DUT presents an output.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_out_valid", out_valid, 0);
                end else begin
                    mon_e = q.pop_front();
                    check("latency_cycle", cyc, mon_e.cyc);
                    check("sprite_R", sprite_R, mon_e.sr);
                    check("sprite_G", sprite_G, mon_e.sg);
                    check("sprite_B", sprite_B, mon_e.sb);
                    check("alpha", alpha, mon_e.a);
                    check("bg_R", bg_R, mon_e.br);
                    check("bg_G", bg_G, mon_e.bgc);
                    check("bg_B", bg_B, mon_e.bb);
                    mon_last = mon_e;
                end
            end else begin
                if (q.size() != 0 && q[0].cyc <= cyc) begin
                    mon_e = q.pop_front();
                    check("missing_out_valid", out_valid, 1);
                end
                if (hold_chk) begin
                    check("hold_sprite_R", sprite_R, mon_last.sr);
                    check("hold_alpha", alpha, mon_last.a);
                    check("hold_bg_R", bg_R, mon_last.br);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         x, y;
        bit         hit;
        logic [7:0] sr;
        logic [9:0] addr;
    } vec_t;
    vec_t edges[7];

    initial begin
        edges[0] = '{99,  52, 1'b0, 8'h00, 10'd0};
        edges[1] = '{132, 52, 1'b0, 8'h00, 10'd0};
        edges[2] = '{131, 81, 1'b1, 8'hFF, 10'd1023};
        edges[3] = '{100, 82, 1'b0, 8'h00, 10'd0};
        edges[4] = '{100, 50, 1'b1, 8'h00, 10'd0};
        edges[5] = '{131, 50, 1'b1, 8'h1F, 10'd31};
        edges[6] = '{100, 81, 1'b1, 8'hE0, 10'd992};

        reset = 1'b1; frame_start = 1'b0; fade_start = 1'b0; pixel_valid = 1'b0;
        sprite_x = '0; sprite_y = '0; pixel_x = '0; pixel_y = '0;
        sdram_R = '0; sdram_G = '0; sdram_B = '0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_alpha", alpha, 0);
        check("reset_sprite_R", sprite_R, 0);
        check("reset_bg_R", bg_R, 0);
        check("reset_rom_addr", rom_addr, 0);
        check("reset_fade_busy", fade_busy, 0);
        reset = 1'b0;

        latch_pos();

        // Hit and latency.
        send_pixel(103, 52, 1'b1, 8'd67, alpha_of(8'hFF, model_level));
        @(negedge clk);
        pixel_valid = 1'b0;
        check("rom_addr_103_52", rom_addr, 10'd67);
        idle(4);

        // Box edges and misses.
        foreach (edges[i]) begin
            send_pixel(edges[i].x, edges[i].y, edges[i].hit, edges[i].sr,
                       alpha_of(8'hFF, model_level));
            @(negedge clk);
            pixel_valid = 1'b0;
            check("rom_addr_edge", rom_addr, edges[i].addr);
        end
        idle(5);

        // Bubbles: 1/0 alternation over 8 cycles, data must hold on the 0s.
        hold_chk = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) send_pixel(104 + i, 53, 1'b1, 8'(100 + i), alpha_of(8'hFF, model_level));
            else idle(1);
        end
        idle(5);
        hold_chk = 1'b0;

`ifdef SPRITE_FADE_EN
        // fade_start with frame_start: level stays 0 for this frame.
        frame(1'b1, 8'd0, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            frame(1'b0, (8 * k > 255) ? 8'd255 : 8'(8 * k), 1'b1);
            if (k == 16) begin
                rom_a = 8'd128;
                send_pixel(103, 52, 1'b1, 8'd67, 8'd64);
                idle(4);
                rom_a = 8'hFF;
            end
        end
        for (int h = 1; h <= 60; h++) begin
            if (h == 10) begin
                @(negedge clk);
                fade_start = 1'b1;
                @(negedge clk);
                fade_start = 1'b0;
                check("fade_busy_ignore", fade_busy, 1);
            end
            frame(1'b0, 8'd255, 1'b1);
        end
        for (int j = 1; j <= 32; j++)
            frame(1'b0, (255 - 8 * j < 0) ? 8'd0 : 8'(255 - 8 * j), j < 32);
        frame(1'b0, 8'd0, 1'b0);

        // Start a new fade so the reset below lands mid-FADE_IN.
        frame(1'b1, 8'd0, 1'b1);
        frame(1'b0, 8'd8, 1'b1);
        frame(1'b0, 8'd16, 1'b1);
`endif

        // Reset with two pixels in flight: neither may emerge.
        @(negedge clk);
        pixel_valid = 1'b1; pixel_x = 10'd105; pixel_y = 10'd55;
        @(negedge clk);
        pixel_x = 10'd106;
        @(negedge clk);
        pixel_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_sprite_R", sprite_R, 0);
        check("rst_sprite_G", sprite_G, 0);
        check("rst_alpha", alpha, 0);
        check("rst_bg_R", bg_R, 0);
        check("rst_bg_B", bg_B, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_fade_busy", fade_busy, 0);
        idle(6);

`ifdef SPRITE_FADE_EN
        model_level = 8'd0;
`endif
        latch_pos();
        send_pixel(103, 52, 1'b1, 8'd67, alpha_of(8'hFF, model_level));
        idle(6);

        check("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
